operand_fetch_unit: RTL and testbench

- Execute-stage front end for the highRISC 16-bit datapath.
- Holds the architectural register file and flags register, and accepts decoded instructions over a valid/ready handshake.
- Registers the ALU operand inputs (Operation, InDest, InSrc, InImm, InFlags).
- Writes the combinational ALU result (OutDest, OutFlags) back to the register file and flags register, with same-cycle forwarding to the next issued instruction.
- Sits between the instruction decoder and ArithmeticLogicUnit.

---
 rtl/operand_fetch_unit.sv | 125 ++++++++++++
 tb/tb_operand_fetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_unit.sv
// Execute-stage front end for the highRISC 16-bit datapath: architectural
// register file, flags register, and one execute slot that registers the
// ALU operands, with the combinational ALU result written back and
// forwarded into the next issued instruction on the same edge.

package operand_fetch_unit_pkg;
  typedef enum logic [1:0] {
    NAND = 2'd0,
    NOR  = 2'd1,
    ADC  = 2'd2,
    LIU  = 2'd3
  } eOperation;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
    logic parity;
  } sFlags;
endpackage

module operand_fetch_unit
  import operand_fetch_unit_pkg::*;
#(
  parameter int DataWidth      = 16,
  parameter int RegAddrWidth   = 3,
  parameter int ImmediateWidth = 6
) (
  input  logic                             Clock,
  input  logic                             nReset,
  // decoder side
  input  logic                             IssueValid,
  output logic                             IssueReady,
  input  eOperation                        IssueOp,
  input  logic        [RegAddrWidth-1:0]   IssueDestReg,
  input  logic        [RegAddrWidth-1:0]   IssueSrcReg,
  input  logic signed [ImmediateWidth-1:0] IssueImm,
  input  logic                             Stall,
  // ALU operand registers
  output eOperation                        Operation,
  output logic signed [DataWidth-1:0]      InDest,
  output logic signed [DataWidth-1:0]      InSrc,
  output logic signed [ImmediateWidth-1:0] InImm,
  output sFlags                            InFlags,
  output logic                             ExValid,
  // ALU result
  input  logic        [DataWidth-1:0]      AluOutDest,
  input  sFlags                            AluOutFlags,
  // architectural state
  output sFlags                            FlagsReg,
  output logic        [15:0]               RetireCount
);

  localparam int NumRegs = 1 << RegAddrWidth;

  logic [NumRegs-1:0][DataWidth-1:0] regs;
  logic [RegAddrWidth-1:0]           ex_dest_reg;

  logic                 transfer;
  logic                 retire;
  logic [DataWidth-1:0] dest_operand;
  logic [DataWidth-1:0] src_operand;
  sFlags                flags_operand;

  // Ready only looks at slot state and Stall so the decoder can never see a
  // combinational path from its own valid/operands back into ready.
  assign IssueReady = !ExValid || !Stall;
  assign transfer   = IssueValid && IssueReady;
  assign retire     = ExValid && !Stall;

  // Operand read with bypass of the result retiring on this same edge, so a
  // dependent instruction issues back-to-back without a bubble.
  always_comb begin
    dest_operand  = regs[IssueDestReg];
    src_operand   = regs[IssueSrcReg];
    flags_operand = FlagsReg;
    if (retire && (ex_dest_reg == IssueDestReg)) dest_operand = AluOutDest;
    if (retire && (ex_dest_reg == IssueSrcReg))  src_operand  = AluOutDest;
    if (retire && (Operation == ADC))            flags_operand = AluOutFlags;
  end

  // Register file: the retire path is the only write port.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)     regs <= '0;
    else if (retire) regs[ex_dest_reg] <= AluOutDest;
  end

  // Flags register: only ADC updates the architectural flags.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)                            FlagsReg <= '0;
    else if (retire && (Operation == ADC))  FlagsReg <= AluOutFlags;
  end

  // Retired-instruction counter, free-running wrap at 16 bits.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)     RetireCount <= '0;
    else if (retire) RetireCount <= RetireCount + 16'd1;
  end

  // Execute slot: load on transfer, drop valid on a retire with no refill.
  // Operand registers are left holding on drain; ExValid qualifies them.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      ExValid     <= 1'b0;
      ex_dest_reg <= '0;
      Operation   <= NAND;
      InDest      <= '0;
      InSrc       <= '0;
      InImm       <= '0;
      InFlags     <= '0;
    end else if (transfer) begin
      ExValid     <= 1'b1;
      ex_dest_reg <= IssueDestReg;
      Operation   <= IssueOp;
      InDest      <= dest_operand;
      InSrc       <= src_operand;
      InImm       <= IssueImm;
      InFlags     <= flags_operand;
    end else if (retire) begin
      ExValid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Randomized bench for operand_fetch_unit against a transaction-level model:
// each edge first commits the retiring result, then the issuing instruction
// reads the (already updated) architectural state.
module tb_operand_fetch_unit;
  import operand_fetch_unit_pkg::*;

  logic        Clock = 1'b0;
  logic        nReset;
  logic        IssueValid;
  logic        IssueReady;
  eOperation   IssueOp;
  logic [2:0]  IssueDestReg, IssueSrcReg;
  logic [5:0]  IssueImm;
  logic        Stall;
  eOperation   Operation;
  logic [15:0] InDest, InSrc;
  logic [5:0]  InImm;
  sFlags       InFlags;
  logic        ExValid;
  logic [15:0] AluOutDest;
  sFlags       AluOutFlags;
  sFlags       FlagsReg;
  logic [15:0] RetireCount;

  operand_fetch_unit dut (
    .Clock(Clock), .nReset(nReset),
    .IssueValid(IssueValid), .IssueReady(IssueReady), .IssueOp(IssueOp),
    .IssueDestReg(IssueDestReg), .IssueSrcReg(IssueSrcReg), .IssueImm(IssueImm),
    .Stall(Stall),
    .Operation(Operation), .InDest(InDest), .InSrc(InSrc), .InImm(InImm),
    .InFlags(InFlags), .ExValid(ExValid),
    .AluOutDest(AluOutDest), .AluOutFlags(AluOutFlags),
    .FlagsReg(FlagsReg), .RetireCount(RetireCount)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: architectural state plus the one in-flight instruction
  logic [15:0] m_regs [8];
  logic [4:0]  m_flags;
  logic [15:0] m_cnt;
  logic        m_valid;
  logic [1:0]  m_op;
  logic [2:0]  m_dst;
  logic [15:0] m_in_dest, m_in_src;
  logic [5:0]  m_in_imm;
  logic [4:0]  m_in_flags;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_flags = '0; m_cnt = '0; m_valid = 1'b0; m_op = 2'd0; m_dst = '0;
    m_in_dest = '0; m_in_src = '0; m_in_imm = '0; m_in_flags = '0;
  endtask

  task automatic model_edge();
    bit ret, xfer;
    ret  = m_valid && !Stall;
    xfer = IssueValid && (!m_valid || !Stall);
    if (ret) begin
      m_regs[m_dst] = AluOutDest;
      if (m_op == 2'(ADC)) m_flags = AluOutFlags;
      m_cnt = m_cnt + 16'd1;
    end
    if (xfer) begin
      m_valid    = 1'b1;
      m_op       = IssueOp;
      m_dst      = IssueDestReg;
      m_in_dest  = m_regs[IssueDestReg];
      m_in_src   = m_regs[IssueSrcReg];
      m_in_imm   = IssueImm;
      m_in_flags = m_flags;
    end else if (ret) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_state();
    chk("ex_valid", 32'(ExValid), 32'(m_valid));
    chk("flags_reg", 32'(FlagsReg), 32'(m_flags));
    chk("retire_count", 32'(RetireCount), 32'(m_cnt));
    chk("operation", 32'(Operation), 32'(m_op));
    chk("in_dest", 32'(InDest), 32'(m_in_dest));
    chk("in_src", 32'(InSrc), 32'(m_in_src));
    chk("in_imm", 32'(InImm), 32'(m_in_imm));
    chk("in_flags", 32'(InFlags), 32'(m_in_flags));
  endtask

  // one cycle: drive after a falling edge, check ready, clock, check state
  task automatic cyc(input logic v, input logic [1:0] op, input logic [2:0] d,
                     input logic [2:0] s, input logic [5:0] imm, input logic st,
                     input logic [15:0] a, input logic [4:0] f);
    IssueValid = v; IssueOp = eOperation'(op); IssueDestReg = d; IssueSrcReg = s;
    IssueImm = imm; Stall = st; AluOutDest = a; AluOutFlags = f;
    #1 chk("issue_ready", 32'(IssueReady), 32'(!m_valid || !st));
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
    check_state();
  endtask

  task automatic cyc_rand(input int stall_pct);
    cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom),
        3'($urandom), 6'($urandom), 1'($urandom_range(0, 99) < stall_pct),
        16'($urandom), 5'($urandom));
  endtask

  initial begin
    nReset = 1'b0; IssueValid = 1'b0; IssueOp = NAND; IssueDestReg = '0;
    IssueSrcReg = '0; IssueImm = '0; Stall = 1'b0; AluOutDest = '0; AluOutFlags = '0;
    model_reset();
    repeat (2) @(negedge Clock);
    chk("reset_ex_valid", 32'(ExValid), 32'd0);
    chk("reset_operation", 32'(Operation), 32'(NAND));
    chk("reset_in_dest", 32'(InDest), 32'd0);
    chk("reset_flags", 32'(FlagsReg), 32'd0);
    chk("reset_count", 32'(RetireCount), 32'd0);
    nReset = 1'b1;

    // basic issue and writeback of R1
    cyc(1, 2'(NAND), 3'd1, 3'd2, 6'd0, 0, 16'h0000, 5'd0);
    chk("basic_valid", 32'(ExValid), 32'd1);
    chk("basic_in_dest", 32'(InDest), 32'h0000);
    cyc(1, 2'(NAND), 3'd4, 3'd1, 6'd5, 0, 16'hFFFF, 5'd0);
    chk("basic_fwd_src", 32'(InSrc), 32'hFFFF);
    cyc(0, 2'(NAND), 3'd0, 3'd0, 6'd0, 0, 16'h1234, 5'd0);
    cyc(1, 2'(NOR), 3'd1, 3'd1, 6'd0, 0, 16'h0000, 5'd0);
    chk("regfile_r1", 32'(InDest), 32'hFFFF);

    // back-to-back dependent ADCs
    cyc(1, 2'(ADC), 3'd2, 3'd1, 6'd1, 0, 16'h0000, 5'd0);
    cyc(1, 2'(ADC), 3'd3, 3'd2, 6'd2, 0, 16'hA5A5, 5'd12);
    chk("b2b_in_src", 32'(InSrc), 32'hA5A5);
    chk("b2b_in_flags", 32'(InFlags), 32'd12);
    chk("b2b_valid", 32'(ExValid), 32'd1);

    // flags policy: ADC updates, NOR does not
    cyc(1, 2'(NOR), 3'd5, 3'd5, 6'd0, 0, 16'h7777, 5'd17);
    cyc(0, 2'(NAND), 3'd0, 3'd0, 6'd0, 0, 16'h0001, 5'd2);
    chk("flags_policy", 32'(FlagsReg), 32'd17);

    // stall with a pending instruction, then release
    cyc(1, 2'(ADC), 3'd6, 3'd6, 6'd3, 0, 16'h0000, 5'd0);
    repeat (3) cyc(1, 2'(NAND), 3'd6, 3'd0, 6'd9, 1, 16'hBEEF, 5'd3);
    cyc(1, 2'(NAND), 3'd6, 3'd0, 6'd9, 0, 16'hBEEF, 5'd3);
    chk("stall_release_fwd", 32'(InDest), 32'hBEEF);
    chk("stall_release_flags", 32'(InFlags), 32'd3);

    // stall with an empty slot does not block issue
    cyc(0, 2'(NAND), 3'd0, 3'd0, 6'd0, 0, 16'h0002, 5'd0);
    cyc(1, 2'(LIU), 3'd7, 3'd3, 6'h2A, 1, 16'h0000, 5'd0);
    chk("stall_empty_issue", 32'(ExValid), 32'd1);

    // randomized traffic
    for (int i = 0; i < 2000; i++) cyc_rand(30);

    // mid-stream async reset with a live instruction
    if (!m_valid) cyc(1, 2'(ADC), 3'd5, 3'd5, 6'd0, 0, 16'h0000, 5'd0);
    IssueValid = 1'b1; Stall = 1'b0; AluOutDest = 16'hCAFE;
    nReset = 1'b0;
    #1;
    model_reset();
    chk("midreset_ex_valid", 32'(ExValid), 32'd0);
    chk("midreset_flags", 32'(FlagsReg), 32'd0);
    chk("midreset_count", 32'(RetireCount), 32'd0);
    @(negedge Clock);
    nReset = 1'b1;
    cyc(1, 2'(NAND), 3'd5, 3'd5, 6'd0, 0, 16'h1111, 5'd0);
    chk("post_reset_r5", 32'(InDest), 32'h0000);
    chk("post_reset_count", 32'(RetireCount), 32'd0);

    for (int i = 0; i < 500; i++) cyc_rand(20);

    // counter wrap: bring the count to FFFF with back-to-back retires
    while (m_cnt != 16'hFFFF)
      cyc(1, 2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 6'($urandom),
          0, 16'($urandom), 5'($urandom));
    chk("count_ffff", 32'(RetireCount), 32'h0000FFFF);
    cyc(1, 2'(NAND), 3'd0, 3'd0, 6'd0, 0, 16'h0000, 5'd0);
    chk("count_wrap", 32'(RetireCount), 32'h00000000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
